add_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares the single 32-bit adder datapath among NUM_REQ requesters.
- Each requester presents an operand pair (A, B) over a valid/ready handshake. The block grants one requester per cycle, computes A+B, and registers the sum.
- The result is returned on one shared response channel, tagged with the requester index.
- Sits between the debug-bench stimulus sources and the adder in the edb-cl Verilator simulation top.

---
 rtl/add_arbiter_if.sv | 63 ++++++
 rtl/add_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_add_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/add_arbiter_if.sv
// -----------------------------------------------------------------------------
// add_arbiter_if
// Purpose : bundles the requester-side and response-side handshake of the
//           shared-adder arbiter into one interface.
//
// Signals :
//   req_valid [NUM_REQ]          per-requester request valid
//   req_ready [NUM_REQ]          per-requester accept, one-hot or zero
//   req_a     [NUM_REQ*DATA_W]   operand A, requester i at [i*DATA_W +: DATA_W]
//   req_b     [NUM_REQ*DATA_W]   operand B, same packing as req_a
//   rsp_valid                    registered result valid
//   rsp_ready                    consumer accepts result
//   rsp_data  [DATA_W]           registered sum, truncated to DATA_W
//   rsp_carry                    carry-out of the unsigned add
//   rsp_id    [ID_W]             index of the requester that produced rsp_data
//   rsp_ovf                      signed overflow (only with ADD_ARB_OVF_EN)
//
// Modports:
//   master : requesters plus result consumer (drives req_*, rsp_ready)
//   slave  : the arbiter itself
//
// Build option: define ADD_ARB_OVF_EN to add the rsp_ovf signal.
// -----------------------------------------------------------------------------
interface add_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [DATA_W-1:0]         rsp_data;
    logic                      rsp_carry;
    logic [ID_W-1:0]           rsp_id;
`ifdef ADD_ARB_OVF_EN
    logic                      rsp_ovf;
`endif

`ifdef ADD_ARB_OVF_EN
    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_carry, rsp_id, rsp_ovf
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_carry, rsp_id, rsp_ovf
    );
`else
    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_carry, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_carry, rsp_id
    );
`endif
endinterface

// File: rtl/add_arbiter.sv
// -----------------------------------------------------------------------------
// add_arbiter
// Purpose : round-robin arbiter that shares one DATA_W-bit adder among
//           NUM_REQ requesters. One requester is granted per cycle, its
//           operands are added, and the sum is registered on a single
//           response channel tagged with the requester index.
//
// Ports   :
//   clk  in   rising-edge clock
//   rst  in   asynchronous reset, active low (0 = reset asserted)
//   bus  slave modport of add_arbiter_if (request and response channels)
//
// Build option: ADD_ARB_OVF_EN adds rsp_ovf, the registered two's-complement
//               overflow of the captured add. Without it the port and its
//               logic are absent; everything else is unchanged.
//
// Timing  : req_ready is combinational from req_valid, rsp_ready and state.
//           Requesters must not make req_valid depend on req_ready.
//           The result appears one cycle after the accept edge, and a full
//           result register can be replaced on the edge it is consumed, so
//           back-to-back grants give one result per cycle.
// -----------------------------------------------------------------------------
module add_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 2
) (
    input  logic          clk,
    input  logic          rst,
    add_arbiter_if.slave  bus
);

    // FSM encoding: IDLE holds no result, HOLD presents a result on rsp_*.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    // Pointer value that makes requester 0 the first winner after reset.
    localparam logic [ID_W-1:0] LAST_GRANT_RST = ID_W'(NUM_REQ - 1);

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // Index of the requester 'off' positions after 'base', wrapping at
    // NUM_REQ (NUM_REQ need not be a power of two).
    function automatic logic [ID_W-1:0] rr_index(
        input logic [ID_W-1:0] base,
        input int unsigned     off
    );
        int unsigned pos;
        pos = 32'(base) + off;
        pos = pos % 32'(NUM_REQ);
        return pos[ID_W-1:0];
    endfunction

    // Unsigned add with the carry kept as the extra top bit.
    function automatic logic [DATA_W:0] add_wide(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        return {1'b0, a} + {1'b0, b};
    endfunction

`ifdef ADD_ARB_OVF_EN
    // Signed overflow: operands agree in sign but the sum does not.
    function automatic logic signed_ovf(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic [DATA_W-1:0] s
    );
        return (a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]);
    endfunction
`endif

    // ------------------------------------------------------------------
    // State and result registers
    // ------------------------------------------------------------------
    logic [0:0]        r_state;
    logic [ID_W-1:0]   r_last_grant;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_carry;
    logic [ID_W-1:0]   r_rsp_id;
`ifdef ADD_ARB_OVF_EN
    logic              r_rsp_ovf;
`endif

    // ------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------
    logic              w_found;
    logic [ID_W-1:0]   w_gnt_idx;
    logic [ID_W-1:0]   w_cand;
    logic              w_can_accept;
    logic              w_xfer;
    logic [NUM_REQ-1:0] w_req_ready;
    logic [DATA_W-1:0] w_op_a;
    logic [DATA_W-1:0] w_op_b;
    logic [DATA_W:0]   w_sum;

    // Round-robin search: walk from farthest to nearest candidate after
    // the last grant so the nearest valid requester overwrites the rest.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_cand    = '0;
        for (int unsigned k = 32'(NUM_REQ); k >= 32'd1; k--) begin
            w_cand    = rr_index(r_last_grant, k);
            w_found   = w_found | bus.req_valid[w_cand];
            w_gnt_idx = bus.req_valid[w_cand] ? w_cand : w_gnt_idx;
        end
    end

    // Accept when empty, or when the held result is being consumed now.
    always_comb begin
        if (r_state == ST_IDLE) begin
            w_can_accept = 1'b1;
        end else if (r_state == ST_HOLD) begin
            w_can_accept = bus.rsp_ready;
        end else begin
            w_can_accept = 1'b0;
        end
    end

    assign w_xfer = w_can_accept & w_found;

    // One-hot grant for the winner, all-zero when nothing can be taken.
    always_comb begin
        if (w_xfer) begin
            w_req_ready = NUM_REQ'(1'b1) << w_gnt_idx;
        end else begin
            w_req_ready = '0;
        end
    end

    // Operand mux into the shared adder.
    assign w_op_a = bus.req_a[int'(w_gnt_idx)*DATA_W +: DATA_W];
    assign w_op_b = bus.req_b[int'(w_gnt_idx)*DATA_W +: DATA_W];
    assign w_sum  = add_wide(w_op_a, w_op_b);

    // Sequencer: capture a granted sum, hold it until consumed, and drop
    // back to IDLE when it is consumed with nothing new to load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= LAST_GRANT_RST;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_carry  <= 1'b0;
            r_rsp_id     <= '0;
`ifdef ADD_ARB_OVF_EN
            r_rsp_ovf    <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_HOLD: begin
                    if (w_xfer) begin
                        r_state      <= ST_HOLD;
                        r_last_grant <= w_gnt_idx;
                        r_rsp_valid  <= 1'b1;
                        r_rsp_data   <= w_sum[DATA_W-1:0];
                        r_rsp_carry  <= w_sum[DATA_W];
                        r_rsp_id     <= w_gnt_idx;
`ifdef ADD_ARB_OVF_EN
                        r_rsp_ovf    <= signed_ovf(w_op_a, w_op_b, w_sum[DATA_W-1:0]);
`endif
                    end else if ((r_state == ST_HOLD) && bus.rsp_ready) begin
                        // Consumed with no new request: payload keeps its
                        // last value, only valid drops.
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                    end else begin
                        r_state     <= r_state;
                        r_rsp_valid <= r_rsp_valid;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to empty.
                    r_state     <= ST_IDLE;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_carry = r_rsp_carry;
    assign bus.rsp_id    = r_rsp_id;
`ifdef ADD_ARB_OVF_EN
    assign bus.rsp_ovf   = r_rsp_ovf;
`endif

endmodule

// File: tb/tb_add_arbiter.sv
// Directed bench for add_arbiter: reset, single request, round-robin,
// backpressure, carry wrap and (when built with ADD_ARB_OVF_EN) overflow.
module tb_add_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 32;
    localparam int ID_W    = 2;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    add_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) u_if ();

    add_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-computed sums for the round-robin operands below.
    logic [31:0] rr_sum [4];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int idx, input logic [31:0] a, input logic [31:0] b);
        u_if.req_a[idx*DATA_W +: DATA_W] = a;
        u_if.req_b[idx*DATA_W +: DATA_W] = b;
    endtask

    // Advance one rising edge and park on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_rsp(input string tag, input logic v, input logic [31:0] d,
                           input logic c, input logic [1:0] id);
        chk({tag, "_valid"}, 64'(u_if.rsp_valid), 64'(v));
        chk({tag, "_data"},  64'(u_if.rsp_data),  64'(d));
        chk({tag, "_carry"}, 64'(u_if.rsp_carry), 64'(c));
        chk({tag, "_id"},    64'(u_if.rsp_id),    64'(id));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rr_sum[0] = 32'd1100;   // 100 + 1000
        rr_sum[1] = 32'd2101;   // 101 + 2000
        rr_sum[2] = 32'd3102;   // 102 + 3000
        rr_sum[3] = 32'd4103;   // 103 + 4000

        rst = 1'b0;
        u_if.req_valid = 4'b0000;
        u_if.req_a     = '0;
        u_if.req_b     = '0;
        u_if.rsp_ready = 1'b0;
        step();
        step();
        chk_rsp("reset", 1'b0, 32'd0, 1'b0, 2'd0);
`ifdef ADD_ARB_OVF_EN
        chk("reset_ovf", 64'(u_if.rsp_ovf), 64'd0);
`endif
        rst = 1'b1;

        // Reset mid-HOLD: 3+4 from requester 1, then asynchronous reset.
        set_op(1, 32'd3, 32'd4);
        u_if.req_valid = 4'b0010;
        #1;
        chk("hold_grant1", 64'(u_if.req_ready), 64'h2);
        step();
        chk_rsp("hold_res", 1'b1, 32'd7, 1'b0, 2'd1);
        u_if.req_valid = 4'b1111;
        #1;
        chk("hold_noready", 64'(u_if.req_ready), 64'h0);
        u_if.req_valid = 4'b0000;
        #1;
        rst = 1'b0;
        #1;
        chk("async_rst_valid", 64'(u_if.rsp_valid), 64'd0);
        chk("async_rst_data",  64'(u_if.rsp_data),  64'd0);
        step();
        rst = 1'b1;

        // Round-robin with all requesters valid and rsp_ready held high.
        set_op(0, 32'd100, 32'd1000);
        set_op(1, 32'd101, 32'd2000);
        set_op(2, 32'd102, 32'd3000);
        set_op(3, 32'd103, 32'd4000);
        u_if.req_valid = 4'b1111;
        u_if.rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("rr_ready%0d", k), 64'(u_if.req_ready), 64'(4'b0001 << (k % 4)));
            step();
            chk_rsp($sformatf("rr%0d", k), 1'b1, rr_sum[k % 4], 1'b0, 2'(k % 4));
        end

        // Backpressure: result from requester 1 held for 5 cycles.
        u_if.rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("bp_ready%0d", k), 64'(u_if.req_ready), 64'h0);
            step();
            chk_rsp($sformatf("bp%0d", k), 1'b1, rr_sum[1], 1'b0, 2'd1);
        end
        u_if.rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(u_if.req_ready), 64'h4);
        step();
        chk_rsp("bp_release", 1'b1, rr_sum[2], 1'b0, 2'd2);

        // Drain: consume with nothing pending, then rsp_ready in IDLE.
        u_if.req_valid = 4'b0000;
        step();
        chk_rsp("drain", 1'b0, rr_sum[2], 1'b0, 2'd2);
        step();
        chk_rsp("idle_ready", 1'b0, rr_sum[2], 1'b0, 2'd2);

        // Single requester 2: 10 + 20.
        u_if.rsp_ready = 1'b0;
        set_op(2, 32'd10, 32'd20);
        u_if.req_valid = 4'b0100;
        #1;
        chk("single_ready", 64'(u_if.req_ready), 64'h4);
        step();
        chk_rsp("single", 1'b1, 32'd30, 1'b0, 2'd2);

        // Carry wrap on requester 0: FFFFFFFF + 2, consumed on the same edge.
        set_op(0, 32'hFFFF_FFFF, 32'h0000_0002);
        u_if.req_valid = 4'b0001;
        u_if.rsp_ready = 1'b1;
        #1;
        chk("wrap_ready", 64'(u_if.req_ready), 64'h1);
        step();
        chk_rsp("wrap2", 1'b1, 32'h0000_0001, 1'b1, 2'd0);
`ifdef ADD_ARB_OVF_EN
        chk("wrap2_ovf", 64'(u_if.rsp_ovf), 64'd0);
`endif

        // FFFFFFFF + 1 on requester 3.
        set_op(3, 32'hFFFF_FFFF, 32'h0000_0001);
        u_if.req_valid = 4'b1000;
        step();
        chk_rsp("wrap1", 1'b1, 32'h0000_0000, 1'b1, 2'd3);

        // Signed overflow on requester 1: 7FFFFFFF + 1.
        set_op(1, 32'h7FFF_FFFF, 32'h0000_0001);
        u_if.req_valid = 4'b0010;
        step();
        chk_rsp("ovf", 1'b1, 32'h8000_0000, 1'b0, 2'd1);
`ifdef ADD_ARB_OVF_EN
        chk("ovf_flag", 64'(u_if.rsp_ovf), 64'd1);
`endif

        u_if.req_valid = 4'b0000;
        step();
        chk("final_valid", 64'(u_if.rsp_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
